vxc_result_collector: RTL and testbench



---
 rtl/vxc_result_collector.sv | 170 +++++++++++++++++
 tb/tb_vxc_result_collector.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vxc_result_collector.sv
// Write-back collector for the complex vector update datapath: aligns issued rows to the
// datapath latency, masks padding lanes of the final row and writes rows to vector memory.
// Optional sticky error output enabled by defining VXC_COLLECT_ERR_EN.
module vxc_result_collector #(
  parameter int NOE           = 19,
  parameter int NI            = 8,
  parameter int element_width = 64,
  parameter int LAT           = 8,
  parameter int AW            = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [AW-1:0]               base_addr,
  input  logic                        in_valid,
  input  logic [element_width*NI-1:0] result,
  output logic                        wr_en,
  output logic [AW-1:0]               wr_addr,
  output logic [element_width*NI-1:0] wr_data,
  output logic                        busy,
  output logic                        done,
`ifdef VXC_COLLECT_ERR_EN
  output logic                        err,
`endif
  output logic [1:0]                  dbg_state
);

  localparam int DW         = element_width * NI;
  localparam int ROWS       = (NOE + NI - 1) / NI;
  localparam int LAST_VALID = NOE % NI;
  localparam int CW         = $clog2(ROWS + 1);
  localparam logic [CW-1:0] ROWS_C   = CW'(ROWS);
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [LAT-1:0]  vpipe_q, vpipe_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accepted;
  logic            sample;
  logic            last_row;
  logic [DW-1:0]   masked;

  // A row issue is a one-cycle in_valid with no back-pressure: it counts only while
  // RUN still owes rows; anything else is dropped and never reaches memory.
  always_comb begin
    accepted = (state_q == S_RUN) && in_valid && (issue_cnt_q < ROWS_C);
    sample   = (state_q == S_RUN) && vpipe_q[LAT-1];
    last_row = (wr_cnt_q == LAST_ROW);
  end

  always_comb begin
    masked = result;
    for (int j = 0; j < NI; j++) begin
      if (last_row && (LAST_VALID != 0) && (j >= LAST_VALID)) begin
        masked[element_width*(NI-j)-1 -: element_width] = '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    vpipe_d     = (vpipe_q << 1) | LAT'(accepted);
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d      = base_addr;
          issue_cnt_d = '0;
          wr_cnt_d    = '0;
          busy_d      = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (accepted) begin
          issue_cnt_d = issue_cnt_q + CW'(1);
        end
        if (sample) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + AW'(wr_cnt_q);
          wr_data_d = masked;
          wr_cnt_d  = wr_cnt_q + CW'(1);
          if (last_row) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      wr_cnt_q    <= '0;
      vpipe_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      vpipe_q     <= vpipe_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef VXC_COLLECT_ERR_EN
  logic err_q, err_d;

  // An accepted start clears the flag, but an error event in that same cycle still sets it.
  always_comb begin
    err_d = ((state_q == S_IDLE) && start) ? 1'b0 : err_q;
    if (in_valid && (state_q != S_RUN)) err_d = 1'b1;
    if (in_valid && (state_q == S_RUN) && (issue_cnt_q == ROWS_C)) err_d = 1'b1;
    if (start && busy_q) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`endif

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vxc_result_collector.sv
// Bench for vxc_result_collector: two instances (NOE=19 and NOE=16) share stimulus; a
// directed vector table, hand sequences and random passes are checked against an event model.
module tb_vxc_result_collector;

  localparam int NI  = 8;
  localparam int EW  = 64;
  localparam int LAT = 8;
  localparam int AW  = 8;
  localparam int DW  = EW * NI;
  localparam int CWD = AW + DW;
  localparam int NE  = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, in_valid;
  logic [AW-1:0] base_addr;
  logic [DW-1:0] result;

  logic          wr_en_o   [2];
  logic [AW-1:0] wr_addr_o [2];
  logic [DW-1:0] wr_data_o [2];
  logic          busy_o    [2];
  logic          done_o    [2];
  logic [1:0]    dbg_o     [2];
`ifdef VXC_COLLECT_ERR_EN
  logic          err_o     [2];
`endif

  vxc_result_collector #(.NOE(19), .NI(NI), .element_width(EW), .LAT(LAT), .AW(AW)) u_dut19 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .in_valid(in_valid),
    .result(result), .wr_en(wr_en_o[0]), .wr_addr(wr_addr_o[0]), .wr_data(wr_data_o[0]),
    .busy(busy_o[0]), .done(done_o[0]),
`ifdef VXC_COLLECT_ERR_EN
    .err(err_o[0]),
`endif
    .dbg_state(dbg_o[0])
  );

  vxc_result_collector #(.NOE(16), .NI(NI), .element_width(EW), .LAT(LAT), .AW(AW)) u_dut16 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .in_valid(in_valid),
    .result(result), .wr_en(wr_en_o[1]), .wr_addr(wr_addr_o[1]), .wr_data(wr_data_o[1]),
    .busy(busy_o[1]), .done(done_o[1]),
`ifdef VXC_COLLECT_ERR_EN
    .err(err_o[1]),
`endif
    .dbg_state(dbg_o[1])
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  int            noe_t [2] = '{19, 16};
  int            rows_t[2];
  bit            m_run [2];
  bit            m_dn  [2];
  int            m_iss [2];
  int            m_wr  [2];
  logic [AW-1:0] m_base[2];
  bit            due   [2][NE];
  int            e = 0;

  logic          x_wr_en[2];
  logic [AW-1:0] x_addr [2];
  logic [DW-1:0] x_data [2];
  logic          x_busy [2];
  logic          x_done [2];
  logic          x_err  [2];

  logic [CWD-1:0] exp_q0[$];
  logic [CWD-1:0] exp_q1[$];

  function automatic logic [DW-1:0] mask_row(input int noe, input int row, input logic [DW-1:0] r);
    logic [DW-1:0] m;
    m = r;
    for (int j = 0; j < NI; j++) begin
      if (row * NI + j >= noe) m[EW*(NI-j)-1 -: EW] = '0;
    end
    return m;
  endfunction

  task automatic model_clear(input int i);
    m_run[i] = 1'b0; m_dn[i] = 1'b0; m_iss[i] = 0; m_wr[i] = 0; m_base[i] = '0;
    x_wr_en[i] = 1'b0; x_addr[i] = '0; x_data[i] = '0;
    x_busy[i] = 1'b0; x_done[i] = 1'b0; x_err[i] = 1'b0;
    for (int k = 0; k < NE; k++) due[i][k] = 1'b0;
    if (i == 0) exp_q0.delete();
    else        exp_q1.delete();
  endtask

  task automatic model_edge();
    bit err_set, start_ok;
    e++;
    for (int i = 0; i < 2; i++) begin
      x_wr_en[i] = 1'b0;
      x_done[i]  = 1'b0;
      if (reset) begin
        model_clear(i);
      end else begin
        err_set  = (in_valid && !m_run[i]) || (in_valid && m_run[i] && m_iss[i] == rows_t[i]) ||
                   (start && x_busy[i]);
        start_ok = start && !m_run[i] && !m_dn[i];
        if (m_dn[i]) begin
          x_done[i] = 1'b1;
          x_busy[i] = 1'b0;
          m_dn[i]   = 1'b0;
        end else if (m_run[i]) begin
          if (due[i][e]) begin
            due[i][e]  = 1'b0;
            x_wr_en[i] = 1'b1;
            x_addr[i]  = m_base[i] + AW'(m_wr[i]);
            x_data[i]  = mask_row(noe_t[i], m_wr[i], result);
            if (i == 0) exp_q0.push_back({x_addr[i], x_data[i]});
            else        exp_q1.push_back({x_addr[i], x_data[i]});
            m_wr[i]++;
            if (m_wr[i] == rows_t[i]) begin
              m_run[i] = 1'b0;
              m_dn[i]  = 1'b1;
            end
          end
          if (in_valid && m_iss[i] < rows_t[i]) begin
            m_iss[i]++;
            if (e + LAT < NE) due[i][e+LAT] = 1'b1;
          end
        end else if (start) begin
          m_run[i]  = 1'b1;
          m_base[i] = base_addr;
          m_iss[i]  = 0;
          m_wr[i]   = 0;
          x_busy[i] = 1'b1;
        end
        x_err[i] = (start_ok ? 1'b0 : x_err[i]) | err_set;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [CWD-1:0] act, input logic [CWD-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [CWD-1:0] got, want;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("wr_en%0d", i),   wr_en_o[i],   x_wr_en[i]);
      chk($sformatf("wr_addr%0d", i), wr_addr_o[i], x_addr[i]);
      chk($sformatf("wr_data%0d", i), wr_data_o[i], x_data[i]);
      chk($sformatf("busy%0d", i),    busy_o[i],    x_busy[i]);
      chk($sformatf("done%0d", i),    done_o[i],    x_done[i]);
`ifdef VXC_COLLECT_ERR_EN
      chk($sformatf("err%0d", i),     err_o[i],     x_err[i]);
`endif
      if (wr_en_o[i] === 1'b1) begin
        got = {wr_addr_o[i], wr_data_o[i]};
        if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          chk($sformatf("sb_unexpected%0d", i), wr_en_o[i], 1'b0);
        end else begin
          want = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("sb_row%0d", i), got, want);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic rnd_result();
    for (int k = 0; k < DW / 32; k++) result[32*k +: 32] = $urandom();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          start;
    logic [AW-1:0] base;
    logic          in_valid;
    logic          e_wr_en;
    logic [AW-1:0] e_addr;
    logic          e_busy;
    logic          e_done;
    logic          chk_data;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl[$];

  task automatic add_seq(input logic [AW-1:0] b, input int i0, input int i1, input int i2,
                         input int w0, input int w1, input int w2, input int dn, input int len,
                         inout logic [AW-1:0] addr);
    vec_t v;
    int wi;
    wi = 0;
    for (int c = 1; c <= len; c++) begin
      v.start    = (c == 1);
      v.base     = b;
      v.in_valid = (c == i0) || (c == i1) || (c == i2);
      v.e_wr_en  = (c == w0) || (c == w1) || (c == w2);
      if (v.e_wr_en) begin
        addr = b + AW'(wi);
        wi++;
      end
      v.e_addr   = addr;
      v.e_busy   = (c < dn);
      v.e_done   = (c == dn);
      v.chk_data = 1'b0;
      v.e_data   = '0;
      tbl.push_back(v);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [AW-1:0] addr_trk;
    logic [DW-1:0] row2_exp;
    int n;

    for (int i = 0; i < 2; i++) rows_t[i] = (noe_t[i] + NI - 1) / NI;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; base_addr = '0; result = '1;
    for (int i = 0; i < 2; i++) model_clear(i);
    repeat (2) tick();
    reset = 1'b0;

    // Back-to-back issues, then gapped issues; all-ones rows expose the final-row mask.
    addr_trk = '0;
    add_seq(8'h10, 2, 3, 4, 10, 11, 12, 13, 15, addr_trk);
    add_seq(8'h20, 2, 5, 9, 10, 13, 17, 18, 20, addr_trk);
    row2_exp = {{3{64'hFFFF_FFFF_FFFF_FFFF}}, 320'h0};
    tbl[9].chk_data  = 1'b1; tbl[9].e_data  = '1;
    tbl[10].chk_data = 1'b1; tbl[10].e_data = '1;
    tbl[11].chk_data = 1'b1; tbl[11].e_data = row2_exp;
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; base_addr = tbl[i].base; in_valid = tbl[i].in_valid;
      tick();
      chk($sformatf("tbl%0d_wr_en", i),   wr_en_o[0],   tbl[i].e_wr_en);
      chk($sformatf("tbl%0d_wr_addr", i), wr_addr_o[0], tbl[i].e_addr);
      chk($sformatf("tbl%0d_busy", i),    busy_o[0],    tbl[i].e_busy);
      chk($sformatf("tbl%0d_done", i),    done_o[0],    tbl[i].e_done);
      if (tbl[i].chk_data) chk($sformatf("tbl%0d_data", i), wr_data_o[0], tbl[i].e_data);
    end
    start = 1'b0; in_valid = 1'b0;

    // Asynchronous reset after the first write, with rows still in flight.
    start = 1'b1; base_addr = 8'h40; tick();
    start = 1'b0; in_valid = 1'b1; repeat (3) tick();
    in_valid = 1'b0; repeat (6) tick();
    #2 reset = 1'b1;
    for (int i = 0; i < 2; i++) model_clear(i);
    #1 compare_all();
    chk("async_rst_wr_en", wr_en_o[0], 1'b0);
    chk("async_rst_busy", busy_o[0], 1'b0);
    tick();
    reset = 1'b0;
    repeat (15) tick();
    start = 1'b1; base_addr = 8'h50; tick();
    start = 1'b0; in_valid = 1'b1; repeat (3) tick();
    in_valid = 1'b0; repeat (12) tick();

    // Extra issue after the quota plus a start while busy.
    start = 1'b1; base_addr = 8'h80; tick();
    start = 1'b0; in_valid = 1'b1; repeat (4) tick();
    in_valid = 1'b0; start = 1'b1; base_addr = 8'h90; tick();
    start = 1'b0; repeat (12) tick();

    // Start landing in the DONE cycle of the 3-row instance.
    start = 1'b1; base_addr = 8'hA0; tick();
    start = 1'b0; in_valid = 1'b1; repeat (3) tick();
    in_valid = 1'b0; repeat (8) tick();
    start = 1'b1; base_addr = 8'hB0; tick();
    start = 1'b0; repeat (4) tick();

    // Random passes with stray starts/issues, random gaps and address wrap.
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = ($urandom_range(0, 3) == 0);
        rnd_result();
        tick();
      end
      start = 1'b1;
      base_addr = ($urandom_range(0, 3) == 0) ? 8'hFE : AW'($urandom_range(0, 255));
      in_valid = $urandom_range(0, 1);
      rnd_result();
      tick();
      start = 1'b0;
      n = 0;
      while ((m_run[0] || m_dn[0] || m_run[1] || m_dn[1]) && n < 80) begin
        in_valid = $urandom_range(0, 1);
        start = ($urandom_range(0, 19) == 0);
        base_addr = AW'($urandom_range(0, 255));
        rnd_result();
        tick();
        n++;
      end
      start = 1'b0; in_valid = 1'b0;
    end

    repeat (LAT + 3) tick();
    chk("sb_drain0", exp_q0.size(), 0);
    chk("sb_drain1", exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
